// File: rtl/mha_attn_sequencer.sv
// Token/head sequencer for the multi-head self-attention pipeline.
// Drives QKV/QK/SMAX/ATTN engines and the KV-cache write port.
module mha_attn_sequencer #(
  parameter int SEQ_LEN = 64,
  parameter int NUM_HEADS = 4,
  parameter int TIMEOUT = 4096,
  localparam int TW = $clog2(SEQ_LEN),
  localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1,
  localparam int CW = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [TW:0]   seq_len_cfg,
  input  logic          causal_en,
  input  logic          abort,
  input  logic [3:0]    stage_done,
  output logic [3:0]    stage_start,
  output logic [TW-1:0] token_idx,
  output logic [HW-1:0] head_idx,
  output logic          kv_write_en,
  output logic [TW-1:0] kv_write_addr,
  output logic [TW:0]   kv_read_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    fsm_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_QKV  = 3'd1;
  localparam logic [2:0] S_QK   = 3'd2;
  localparam logic [2:0] S_SMAX = 3'd3;
  localparam logic [2:0] S_ATTN = 3'd4;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [TW:0]   LEN_MAX   = (TW+1)'(SEQ_LEN);
  localparam logic [TW:0]   LEN_ONE   = (TW+1)'(1);
  localparam logic [HW-1:0] HEAD_LAST = HW'(NUM_HEADS - 1);
  localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic          first;
  logic          hold;
  logic          causal;
  logic          err_q;
  logic [TW:0]   len;
  logic [TW-1:0] token;
  logic [HW-1:0] head;
  logic [CW-1:0] wd;
  logic          kv_we;
  logic [TW-1:0] kv_addr;

  logic [3:0] act;
  logic       hit;
  logic       in_score;
  logic       last_tok;
  logic       last_head;
  logic       wd_hit;

  always_comb begin
    act = 4'b0000;
    unique case (1'b1)
      (state == S_QKV):  act = 4'b0001;
      (state == S_QK):   act = 4'b0010;
      (state == S_SMAX): act = 4'b0100;
      (state == S_ATTN): act = 4'b1000;
      default:           act = 4'b0000;
    endcase
  end

  // a done seen in the entry cycle belongs to nobody
  assign hit       = ~first & |(stage_done & act);
  assign in_score  = act[1] | act[2] | act[3];
  assign last_tok  = ({1'b0, token} == (len - LEN_ONE));
  assign last_head = (head == HEAD_LAST);
  assign wd_hit    = (wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      first   <= 1'b0;
      hold    <= 1'b0;
      causal  <= 1'b0;
      err_q   <= 1'b0;
      len     <= '0;
      token   <= '0;
      head    <= '0;
      wd      <= '0;
      kv_we   <= 1'b0;
      kv_addr <= '0;
    end else begin
      first <= 1'b0;
      kv_we <= 1'b0;
      wd    <= wd + CW'(1);
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            token  <= '0;
            head   <= '0;
            causal <= causal_en;
            len    <= (seq_len_cfg > LEN_MAX) ? LEN_MAX : seq_len_cfg;
            if (seq_len_cfg == '0) begin
              // extra DONE cycle lines up with a normal completion
              err_q <= 1'b1;
              hold  <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q <= 1'b0;
              first <= 1'b1;
              wd    <= '0;
              state <= S_QKV;
            end
          end
        end
        S_QKV, S_QK, S_SMAX, S_ATTN: begin
          if (hit) begin
            first <= 1'b1;
            wd    <= '0;
            unique case (1'b1)
              act[0]: begin
                kv_we   <= 1'b1;
                kv_addr <= token;
                if (causal) begin
                  state <= S_QK;
                end else if (!last_tok) begin
                  token <= token + TW'(1);
                  state <= S_QKV;
                end else begin
                  token <= '0;
                  state <= S_QK;
                end
              end
              act[1]: state <= S_SMAX;
              act[2]: state <= S_ATTN;
              default: begin
                if (!last_head) begin
                  head  <= head + HW'(1);
                  state <= S_QK;
                end else begin
                  head <= '0;
                  if (last_tok) begin
                    first <= 1'b0;
                    state <= S_DONE;
                  end else begin
                    token <= token + TW'(1);
                    state <= causal ? S_QKV : S_QK;
                  end
                end
              end
            endcase
          end else if (wd_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (hold) hold <= 1'b0;
          else state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        first <= 1'b0;
        hold  <= 1'b0;
        kv_we <= 1'b0;
        err_q <= err_q;
      end
    end
  end

  assign stage_start   = first ? act : 4'b0000;
  assign token_idx     = token;
  assign head_idx      = head;
  assign kv_write_en   = kv_we;
  assign kv_write_addr = kv_addr;
  assign kv_read_len   = !in_score ? '0 :
                         causal ? ({1'b0, token} + LEN_ONE) : len;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE) & ~hold & ~abort;
  assign err           = err_q;
  assign fsm_state     = state;

endmodule
